// File: rtl/ripple_counter_4bit.sv
// ripple_counter_4bit: registered 4-bit ripple-carry adder with carry-out, signed-overflow and zero flags
module rca_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module ripple_counter_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] result,
    output logic       cout,
    output logic       ovf,
    output logic       zero,
    input  logic       clk,
    input  logic       rst
);
    logic [4:0] c;
    logic [3:0] s;
    logic [3:0] result_d, result_q;
    logic       cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;
    assign c[0] = cin;
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            rca_full_adder u_fa (
                .a_i(a[i]),
                .b_i(b[i]),
                .c_i(c[i]),
                .s_o(s[i]),
                .c_o(c[i+1])
            );
        end
    endgenerate
    // signed overflow is the disagreement between carry into and out of the sign bit
    always_comb begin
        result_d = s;
        cout_d   = c[4];
        ovf_d    = c[3] ^ c[4];
        zero_d   = ~|s;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= 4'b0000;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;
endmodule

// File: tb/tb_ripple_counter_4bit.sv
// tb_ripple_counter_4bit: directed and exhaustive checks of the registered ripple adder
module tb_ripple_counter_4bit;
    logic [3:0] a, b, result;
    logic       cin, cout, ovf, zero, clk, rst;
    int         n_chk, n_fail;

    ripple_counter_4bit dut (
        .a(a), .b(b), .cin(cin), .result(result), .cout(cout),
        .ovf(ovf), .zero(zero), .clk(clk), .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observed and expected are packed as {result, cout, ovf, zero}
    task automatic check(input string tag, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got res=%h cout=%b ovf=%b zero=%b, want res=%h cout=%b ovf=%b zero=%b",
                     tag, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [6:0] model(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [4:0] full;
        logic [3:0] low;
        full = 5'(x) + 5'(y) + 5'(ci);
        low  = 4'(x[2:0]) + 4'(y[2:0]) + 4'(ci);
        return {full[3:0], full[4], low[3] ^ full[4], full[3:0] == 4'd0};
    endfunction

    task automatic step(input string tag, input logic [3:0] x, input logic [3:0] y,
                        input logic ci, input logic [6:0] exp);
        a = x; b = y; cin = ci;
        @(posedge clk); #1;
        check(tag, {result, cout, ovf, zero}, exp);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b0; a = 4'hF; b = 4'hF; cin = 1'b1;
        #3 rst = 1'b1;
        #1 check("rst_async", {result, cout, ovf, zero}, 7'b0000_000);
        repeat (3) @(posedge clk);
        #1 check("rst_held", {result, cout, ovf, zero}, 7'b0000_000);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release", {result, cout, ovf, zero}, {4'hF, 1'b1, 1'b0, 1'b0});

        step("add_5_3",  4'd5, 4'd3,    1'b0, {4'd8, 1'b0, 1'b1, 1'b0});
        step("add_4_5",  4'd4, 4'd5,    1'b0, {4'd9, 1'b0, 1'b1, 1'b0});
        step("add_4_2",  4'd4, 4'd2,    1'b0, {4'd6, 1'b0, 1'b0, 1'b0});
        step("sub_3_2",  4'd3, 4'b1101, 1'b1, {4'd1, 1'b1, 1'b0, 1'b0});
        step("wrap_f_1", 4'hF, 4'h0,    1'b1, {4'd0, 1'b1, 1'b0, 1'b1});
        step("add_8_8",  4'd8, 4'd8,    1'b0, {4'd0, 1'b1, 1'b1, 1'b1});
        step("add_7_1",  4'd7, 4'd1,    1'b0, {4'd8, 1'b0, 1'b1, 1'b0});
        step("add_0_0",  4'd0, 4'd0,    1'b0, {4'd0, 1'b0, 1'b0, 1'b1});

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step("sweep", v[3:0], v[7:4], v[8], model(v[3:0], v[7:4], v[8]));
            if (i == 256) begin
                #2 rst = 1'b1;
                #1 check("rst_mid", {result, cout, ovf, zero}, 7'b0000_000);
                @(posedge clk); #1;
                check("rst_mid_held", {result, cout, ovf, zero}, 7'b0000_000);
                rst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
